// File: rtl/serial_tx.sv
// Parallel-load serial transmitter with start/stop framing.
// Each bit is held DIV clocks; all outputs are registered.
module serial_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             RES,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic             Q,
  output logic             BUSY,
  output logic             DONE
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_n;
  logic [WIDTH-1:0] sh_adv;
  logic [DW-1:0]    div_cnt;
  logic [DW-1:0]    div_n;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_n;
  logic             q_n;
  logic             busy_n;
  logic             done_n;
  logic             div_end;

  function automatic logic first_bit(
    input logic [WIDTH-1:0] s
  );
    return LSB_FIRST ? s[0] : s[WIDTH-1];
  endfunction

  assign div_end = (div_cnt == DIV_LAST);
  // The next data bit always sits at the outgoing end.
  assign sh_adv  = LSB_FIRST ? (sh >> 1)
                             : (sh << 1);

  always_comb begin
    state_n = state;
    sh_n    = sh;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    q_n     = Q;
    busy_n  = BUSY;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        q_n    = 1'b1;
        busy_n = 1'b0;
        if (LD) begin
          state_n = START;
          sh_n    = D;
          div_n   = '0;
          bit_n   = '0;
          q_n     = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (div_end) begin
          state_n = DATA;
          div_n   = '0;
          bit_n   = '0;
          q_n     = first_bit(sh);
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      DATA: begin
        if (div_end) begin
          div_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = STOP;
            q_n     = 1'b1;
          end else begin
            bit_n = bit_cnt + 1'b1;
            sh_n  = sh_adv;
            q_n   = first_bit(sh_adv);
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      STOP: begin
        if (div_end) begin
          state_n = IDLE;
          div_n   = '0;
          q_n     = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        q_n     = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RES) begin
      state   <= IDLE;
      sh      <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      Q       <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      Q       <= q_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default, DIV=1 and MSB-first
// instances sharing clock and reset.
module tb_serial_tx;

  logic       ck;
  logic       res;
  logic [2:0] ld;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [2:0] q;
  logic [2:0] busy;
  logic [2:0] done;

  int errs;
  int checks;

  serial_tx #(.WIDTH(8), .DIV(4), .LSB_FIRST(1'b1)) u_dut (
    .CK(ck), .RES(res), .LD(ld[0]), .D(d0),
    .Q(q[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  serial_tx #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b1)) u_div1 (
    .CK(ck), .RES(res), .LD(ld[1]), .D(d1),
    .Q(q[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  serial_tx #(.WIDTH(8), .DIV(4), .LSB_FIRST(1'b0)) u_msb (
    .CK(ck), .RES(res), .LD(ld[2]), .D(d2),
    .Q(q[2]), .BUSY(busy[2]), .DONE(done[2])
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_d(input int sel, input logic [7:0] v);
    case (sel)
      0: d0 = v;
      1: d1 = v;
      default: d2 = v;
    endcase
  endtask

  task automatic chk_idle(input int sel, input string tag);
    check({tag, ".q"}, 32'(q[sel]), 32'd1);
    check({tag, ".busy"}, 32'(busy[sel]), 32'd0);
    check({tag, ".done"}, 32'(done[sel]), 32'd0);
  endtask

  // Called right after the accepting edge E0; walks the frame.
  task automatic check_frame(
    input int         sel,
    input logic [7:0] w,
    input int         div,
    input bit         lsb,
    input int         inj,
    input int         abort,
    input string      tag
  );
    int   n;
    int   s;
    logic eq;
    n = 10 * div;
    for (int j = 0; j < n; j++) begin
      s = j / div;
      if (s == 0)      eq = 1'b0;
      else if (s == 9) eq = 1'b1;
      else             eq = lsb ? w[s-1] : w[8-s];
      check($sformatf("%s.q%0d", tag, j), 32'(q[sel]), 32'(eq));
      check($sformatf("%s.busy%0d", tag, j), 32'(busy[sel]), 32'd1);
      check($sformatf("%s.done%0d", tag, j), 32'(done[sel]), 32'd0);
      if (j == abort) begin
        res = 1'b1;
        tick();
        res = 1'b0;
        chk_idle(sel, {tag, ".abort"});
        for (int k = 0; k < 45; k++) begin
          tick();
          chk_idle(sel, $sformatf("%s.post%0d", tag, k));
        end
        return;
      end
      if (j == inj) begin
        ld[sel] = 1'b1;
        set_d(sel, 8'hFF);
      end else if (j == inj + 1) begin
        ld[sel] = 1'b0;
      end
      tick();
    end
    check({tag, ".end_q"}, 32'(q[sel]), 32'd1);
    check({tag, ".end_busy"}, 32'(busy[sel]), 32'd0);
    check({tag, ".end_done"}, 32'(done[sel]), 32'd1);
  endtask

  task automatic start(input int sel, input logic [7:0] w);
    set_d(sel, w);
    ld[sel] = 1'b1;
    tick();
    ld[sel] = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    res    = 1'b1;
    ld     = 3'b111;
    d0     = 8'hFF;
    d1     = 8'hFF;
    d2     = 8'hFF;

    // reset with load pending
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int s = 0; s < 3; s++)
        chk_idle(s, $sformatf("rst%0d_%0d", i, s));
    end
    res = 1'b0;
    ld  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int s = 0; s < 3; s++)
        chk_idle(s, $sformatf("idle%0d_%0d", i, s));
    end

    // single A5 frame
    start(0, 8'hA5);
    check_frame(0, 8'hA5, 4, 1'b1, -5, -1, "a5");
    tick();
    chk_idle(0, "a5.after");

    // load while busy is ignored; D change mid-frame too
    start(0, 8'h3C);
    check_frame(0, 8'h3C, 4, 1'b1, 10, -1, "busy");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_idle(0, $sformatf("busy.none%0d", k));
    end

    // reset mid-frame, then an all-zero frame
    start(0, 8'hA5);
    check_frame(0, 8'hA5, 4, 1'b1, -5, 15, "abort");
    start(0, 8'h00);
    check_frame(0, 8'h00, 4, 1'b1, -5, -1, "zero");
    tick();

    // back-to-back with LD held
    d0    = 8'h81;
    ld[0] = 1'b1;
    tick();
    d0 = 8'h7E;
    check_frame(0, 8'h81, 4, 1'b1, -5, -1, "b2b1");
    tick();
    ld[0] = 1'b0;
    check_frame(0, 8'h7E, 4, 1'b1, -5, -1, "b2b2");
    tick();
    chk_idle(0, "b2b.after");

    // parameter corners
    start(1, 8'hA5);
    check_frame(1, 8'hA5, 1, 1'b1, -5, -1, "div1");
    start(2, 8'h01);
    check_frame(2, 8'h01, 4, 1'b0, -5, -1, "msb");
    tick();
    chk_idle(1, "div1.after");
    chk_idle(2, "msb.after");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
